vx_vwb_sequencer: RTL and testbench



---
 rtl/vx_vwb_sequencer.sv | 128 ++++++++++++
 tb/tb_vx_vwb_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_vwb_sequencer.sv
// Vector writeback sequencer: takes one full-vector result packet and emits it as
// SIMD_WIDTH-wide writeback beats with per-lane masks and sop/eop framing.
module vx_vwb_sequencer #(
  parameter int unsigned SIMD_WIDTH    = 4,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MAX_VL        = 16,
  parameter int unsigned NR_BITS       = 6,
  parameter int unsigned NW_BITS       = 2,
  parameter int unsigned UUID_WIDTH    = 44,
  parameter int unsigned PC_BITS       = 30,
  parameter int unsigned PERF_CTR_BITS = 44,
  localparam int unsigned NUM_BEATS    = MAX_VL / SIMD_WIDTH,
  localparam int unsigned SIMD_IDX_W   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
  localparam int unsigned VL_WIDTH     = $clog2(MAX_VL + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [UUID_WIDTH-1:0]      res_uuid,
  input  logic [NW_BITS-1:0]         res_wid,
  input  logic [PC_BITS-1:0]         res_pc,
  input  logic [NR_BITS-1:0]         res_rd,
  input  logic                       res_wb,
  input  logic [VL_WIDTH-1:0]        res_vl,
  input  logic [MAX_VL*XLEN-1:0]     res_data,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [UUID_WIDTH-1:0]      wb_uuid,
  output logic [NW_BITS-1:0]         wb_wid,
  output logic [PC_BITS-1:0]         wb_pc,
  output logic [NR_BITS-1:0]         wb_rd,
  output logic [SIMD_IDX_W-1:0]      wb_simd_idx,
  output logic [SIMD_WIDTH-1:0]      wb_mask,
  output logic [SIMD_WIDTH*XLEN-1:0] wb_data,
  output logic                       wb_sop,
  output logic                       wb_eop,
  output logic                       busy,
  output logic [PERF_CTR_BITS-1:0]   perf_stalls
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                   state_q;
  logic [UUID_WIDTH-1:0]    uuid_q;
  logic [NW_BITS-1:0]       wid_q;
  logic [PC_BITS-1:0]       pc_q;
  logic [NR_BITS-1:0]       rd_q;
  logic [MAX_VL*XLEN-1:0]   data_q;
  logic [VL_WIDTH-1:0]      vl_q;
  logic [SIMD_IDX_W-1:0]    beat_q;
  logic [PERF_CTR_BITS-1:0] perf_q;

  logic [SIMD_IDX_W:0]      last_beat;
  logic [VL_WIDTH-1:0]      vl_clamped;
  logic                     wb_fire;
  logic                     load;

  assign busy        = (state_q == StSend);
  assign wb_valid    = busy;
  assign wb_uuid     = uuid_q;
  assign wb_wid      = wid_q;
  assign wb_pc       = pc_q;
  assign wb_rd       = rd_q;
  assign wb_simd_idx = beat_q;
  assign perf_stalls = perf_q;
  assign wb_sop      = busy && (beat_q == '0);
  assign wb_eop      = busy && ({1'b0, beat_q} == last_beat);
  assign wb_fire     = busy && wb_ready;
  // Bypass lets the next packet load in the same cycle the current eop drains.
  assign res_ready   = !busy || (wb_ready && wb_eop);
  assign load        = res_valid && res_ready && res_wb;
  assign vl_clamped  = (res_vl > VL_WIDTH'(MAX_VL)) ? VL_WIDTH'(MAX_VL) : res_vl;

  // An empty vector still gets one (fully masked) beat so the scoreboard releases.
  always_comb begin
    int unsigned nb;
    nb = (int'(vl_q) + SIMD_WIDTH - 1) / SIMD_WIDTH;
    if (nb == 0) nb = 1;
    last_beat = (SIMD_IDX_W + 1)'(nb - 1);
  end

  always_comb begin
    logic [VL_WIDTH:0] lane;
    wb_mask = '0;
    wb_data = '0;
    lane    = '0;
    for (int j = 0; j < SIMD_WIDTH; j++) begin
      lane       = (VL_WIDTH + 1)'(int'(beat_q) * SIMD_WIDTH + j);
      wb_mask[j] = busy && (lane < {1'b0, vl_q});
      wb_data[j*XLEN +: XLEN] = data_q[(int'(beat_q) * SIMD_WIDTH + j) * XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      uuid_q  <= '0;
      wid_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      vl_q    <= '0;
      beat_q  <= '0;
      perf_q  <= '0;
    end else begin
      if (busy && !wb_ready) perf_q <= perf_q + PERF_CTR_BITS'(1);
      if (load) begin
        uuid_q  <= res_uuid;
        wid_q   <= res_wid;
        pc_q    <= res_pc;
        rd_q    <= res_rd;
        data_q  <= res_data;
        vl_q    <= vl_clamped;
        beat_q  <= '0;
        state_q <= StSend;
      end else if (wb_fire) begin
        if (wb_eop) begin
          beat_q  <= '0;
          state_q <= StIdle;
        end else begin
          beat_q <= beat_q + SIMD_IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_vwb_sequencer.sv
// Self-checking bench for vx_vwb_sequencer: random packets checked against a
// per-packet beat model built from element indices and the VL rule.
module tb_vx_vwb_sequencer;

  localparam int SW = 4;
  localparam int XL = 32;
  localparam int MV = 16;
  localparam int NB = MV / SW;

  typedef struct packed {
    logic [MV*XL-1:0] data;
    logic [4:0]       vl;
    logic [43:0]      uuid;
    logic [1:0]       wid;
    logic [29:0]      pc;
    logic [5:0]       rd;
  } pkt_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           res_valid = 1'b0;
  logic           res_ready;
  logic [43:0]    res_uuid = '0;
  logic [1:0]     res_wid = '0;
  logic [29:0]    res_pc = '0;
  logic [5:0]     res_rd = '0;
  logic           res_wb = 1'b0;
  logic [4:0]     res_vl = '0;
  logic [MV*XL-1:0] res_data = '0;
  logic           wb_valid;
  logic           wb_ready = 1'b1;
  logic [43:0]    wb_uuid;
  logic [1:0]     wb_wid;
  logic [29:0]    wb_pc;
  logic [5:0]     wb_rd;
  logic [1:0]     wb_simd_idx;
  logic [3:0]     wb_mask;
  logic [SW*XL-1:0] wb_data;
  logic           wb_sop;
  logic           wb_eop;
  logic           busy;
  logic [43:0]    perf_stalls;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vx_vwb_sequencer dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_uuid(res_uuid), .res_wid(res_wid), .res_pc(res_pc), .res_rd(res_rd),
    .res_wb(res_wb), .res_vl(res_vl), .res_data(res_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_simd_idx(wb_simd_idx), .wb_mask(wb_mask), .wb_data(wb_data),
    .wb_sop(wb_sop), .wb_eop(wb_eop), .busy(busy), .perf_stalls(perf_stalls)
  );

  // Reference model: beat k of packet p as {valid, sop, eop, mask, simd_idx}.
  function automatic logic [8:0] exp_ctl(pkt_t p, int k);
    int vle, nb;
    logic [3:0] m;
    vle = (int'(p.vl) > MV) ? MV : int'(p.vl);
    nb  = (vle == 0) ? 1 : (vle + SW - 1) / SW;
    for (int j = 0; j < SW; j++) m[j] = ((k * SW + j) < vle);
    return {1'b1, (k == 0), (k == nb - 1), m, 2'(k)};
  endfunction

  function automatic logic [SW*XL-1:0] exp_data(pkt_t p, int k);
    logic [SW*XL-1:0] r;
    for (int j = 0; j < SW; j++) r[j*XL +: XL] = p.data[(k * SW + j) * XL +: XL];
    return r;
  endfunction

  function automatic pkt_t rand_pkt(int vl);
    pkt_t p;
    for (int i = 0; i < MV; i++) p.data[i*XL +: XL] = $urandom();
    p.vl   = 5'(vl);
    p.uuid = 44'({$urandom(), $urandom()});
    p.wid  = 2'($urandom());
    p.pc   = 30'($urandom());
    p.rd   = 6'($urandom());
    return p;
  endfunction

  task automatic drive_res(pkt_t p, logic wb);
    res_valid = 1'b1;
    res_uuid  = p.uuid;
    res_wid   = p.wid;
    res_pc    = p.pc;
    res_rd    = p.rd;
    res_vl    = p.vl;
    res_data  = p.data;
    res_wb    = wb;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx, busy} !== 10'b0)
      $display("FAIL reset_ctl: got %b want 0", {wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx, busy});
    else passed++;
    checks++;
    if (res_ready !== 1'b1) $display("FAIL reset_res_ready: got %b want 1", res_ready);
    else passed++;
    checks++;
    if ({wb_data, wb_uuid, wb_wid, wb_pc, wb_rd, perf_stalls} !== '0)
      $display("FAIL reset_regs: got nonzero data/tags/perf (perf=%0d)", perf_stalls);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_vl;
    pkt_t p;
    p = rand_pkt(16);
    for (int i = 0; i < MV; i++) p.data[i*XL +: XL] = 32'(i);
    drive_res(p, 1'b1);
    @(negedge clk);
    res_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      checks++;
      if ({wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx} !== exp_ctl(p, k))
        $display("FAIL full_ctl beat %0d: got %b want %b", k,
                 {wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx}, exp_ctl(p, k));
      else passed++;
      checks++;
      if (wb_data !== exp_data(p, k))
        $display("FAIL full_data beat %0d: got %h want %h", k, wb_data, exp_data(p, k));
      else passed++;
      if (k == 0) begin
        checks++;
        if ({wb_uuid, wb_wid, wb_pc, wb_rd} !== {p.uuid, p.wid, p.pc, p.rd})
          $display("FAIL full_tags: got rd %0d want %0d", wb_rd, p.rd);
        else passed++;
      end
      if (k == 2) begin
        checks++;
        if (wb_data !== {32'd11, 32'd10, 32'd9, 32'd8})
          $display("FAIL full_beat2_const: got %h", wb_data);
        else passed++;
      end
      @(negedge clk);
    end
    checks++;
    if (wb_valid !== 1'b0) $display("FAIL full_end: got wb_valid %b want 0", wb_valid);
    else passed++;
  endtask

  task automatic test_partial_vl;
    pkt_t p;
    p = rand_pkt(6);
    drive_res(p, 1'b1);
    @(negedge clk);
    res_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx} !== exp_ctl(p, k) ||
          wb_data !== exp_data(p, k))
        $display("FAIL partial beat %0d: got %b/%h want %b/%h", k,
                 {wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx}, wb_data,
                 exp_ctl(p, k), exp_data(p, k));
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (wb_valid !== 1'b0) $display("FAIL partial_no_beat2: got wb_valid %b want 0", wb_valid);
    else passed++;
  endtask

  task automatic test_zero_discard;
    pkt_t p;
    p = rand_pkt(0);
    drive_res(p, 1'b1);
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if ({wb_valid, wb_sop, wb_eop, wb_mask} !== 7'b1110000)
      $display("FAIL zero_vl beat: got %b want 1110000", {wb_valid, wb_sop, wb_eop, wb_mask});
    else passed++;
    @(negedge clk);
    p = rand_pkt(12);
    drive_res(p, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      res_valid = 1'b0;
      checks++;
      if (wb_valid !== 1'b0 || res_ready !== 1'b1)
        $display("FAIL discard cycle %0d: got valid %b ready %b want 0/1", c, wb_valid, res_ready);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    pkt_t p;
    logic [43:0] s0;
    p = rand_pkt(16);
    drive_res(p, 1'b1);
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    wb_ready = 1'b0;
    s0 = perf_stalls;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx} !== exp_ctl(p, 1) ||
          wb_data !== exp_data(p, 1) || res_ready !== 1'b0)
        $display("FAIL bp_hold cycle %0d: got %b/%h ready %b want %b/%h ready 0", c,
                 {wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx}, wb_data, res_ready,
                 exp_ctl(p, 1), exp_data(p, 1));
      else passed++;
      @(negedge clk);
    end
    wb_ready = 1'b1;
    checks++;
    if (perf_stalls !== s0 + 44'd3)
      $display("FAIL bp_perf: got %0d want %0d", perf_stalls, s0 + 44'd3);
    else passed++;
    for (int k = 1; k < NB; k++) begin
      checks++;
      if ({wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx} !== exp_ctl(p, k))
        $display("FAIL bp_resume beat %0d: got %b want %b", k,
                 {wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx}, exp_ctl(p, k));
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    pkt_t a, b;
    a = rand_pkt(8);
    b = rand_pkt(8);
    drive_res(a, 1'b1);
    @(negedge clk);
    drive_res(b, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) res_valid = 1'b0;
      checks++;
      if ({wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx} !==
          ((k < 2) ? exp_ctl(a, k) : exp_ctl(b, k - 2)) ||
          wb_data !== ((k < 2) ? exp_data(a, k) : exp_data(b, k - 2)) ||
          wb_rd !== ((k < 2) ? a.rd : b.rd))
        $display("FAIL b2b beat %0d: got %b rd %0d want %b rd %0d", k,
                 {wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx}, wb_rd,
                 (k < 2) ? exp_ctl(a, k) : exp_ctl(b, k - 2), (k < 2) ? a.rd : b.rd);
      else passed++;
      if (k < 2) begin
        checks++;
        if (res_ready !== (k == 1))
          $display("FAIL b2b_res_ready beat %0d: got %b want %b", k, res_ready, (k == 1));
        else passed++;
      end
      @(negedge clk);
    end
    checks++;
    if (wb_valid !== 1'b0) $display("FAIL b2b_end: got wb_valid %b want 0", wb_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_clamp;
    pkt_t p;
    p = rand_pkt(16);
    drive_res(p, 1'b1);
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_mask !== 4'b0)
      $display("FAIL reset_mid: got valid %b busy %b mask %b want 0/0/0", wb_valid, busy, wb_mask);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    p = rand_pkt(20);
    drive_res(p, 1'b1);
    @(negedge clk);
    res_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      checks++;
      if ({wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx} !== exp_ctl(p, k) ||
          wb_data !== exp_data(p, k))
        $display("FAIL clamp beat %0d: got %b want %b", k,
                 {wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx}, exp_ctl(p, k));
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (wb_valid !== 1'b0) $display("FAIL clamp_end: got wb_valid %b want 0", wb_valid);
    else passed++;
  endtask

  task automatic test_random;
    pkt_t p;
    logic [8:0] e;
    for (int n = 0; n < 8; n++) begin
      p = rand_pkt(int'($urandom_range(0, 20)));
      drive_res(p, 1'b1);
      @(negedge clk);
      res_valid = 1'b0;
      for (int k = 0; k < NB; k++) begin
        e = exp_ctl(p, k);
        if ($urandom_range(0, 1) == 1) begin
          wb_ready = 1'b0;
          @(negedge clk);
          wb_ready = 1'b1;
        end
        checks++;
        if ({wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx} !== e || wb_data !== exp_data(p, k))
          $display("FAIL rand pkt %0d beat %0d vl %0d: got %b want %b", n, k, p.vl,
                   {wb_valid, wb_sop, wb_eop, wb_mask, wb_simd_idx}, e);
        else passed++;
        if (e[6]) break;
        @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b0) $display("FAIL rand_end pkt %0d: got wb_valid %b want 0", n, wb_valid);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_full_vl();
    test_partial_vl();
    test_zero_discard();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_clamp();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
